reg_dump_reader: RTL and testbench
==================================

REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, register data width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers to dump.
REQ-003 SHALL have port CLK, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port RST, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port Start, input, 1, request a full dump; sampled only in IDLE.
REQ-006 SHALL have port Abort, input, 1, cancel a dump in progress.
REQ-007 SHALL have port A, output, 5, read address driven to the register-file read port.
REQ-008 SHALL have port RD, input, WIDTH, combinational read data returned for A.
REQ-009 SHALL have port Out_Data, output, WIDTH, captured register value.
REQ-010 SHALL have port Out_Addr, output, 5, index of the register in Out_Data.
REQ-011 SHALL have port Out_Valid, output, 1, Out_Data/Out_Addr are valid.
REQ-012 SHALL have port Out_Ready, input, 1, consumer accepts the word.
REQ-013 SHALL have port Busy, output, 1, high in any state other than IDLE.
REQ-014 SHALL have port Done, output, 1, one-cycle pulse after the last word is accepted.
REQ-015 SHALL have port Checksum, output, WIDTH, XOR of all words captured in the current or last dump.

Function
REQ-016 SHALL implement the FSM states IDLE, FETCH, SEND and FINISH.
REQ-017 In IDLE, Start=1 SHALL move the FSM to FETCH, set index to 0 and clear Checksum.
REQ-018 In FETCH, A SHALL equal index.
REQ-019 On the FETCH clock edge, the block SHALL load RD into Out_Data and index into Out_Addr, set Out_Valid=1, XOR RD into Checksum, and move to SEND.
REQ-020 In SEND, Out_Data, Out_Addr and Out_Valid SHALL be held stable while Out_Ready=0.
REQ-021 In SEND with Out_Ready=1 and index<DEPTH-1, the block SHALL clear Out_Valid, increment index and return to FETCH.
REQ-022 In SEND with Out_Ready=1 and index=DEPTH-1, the block SHALL clear Out_Valid and move to FINISH; index SHALL never wrap.
REQ-023 FINISH SHALL assert Done for exactly one cycle and then return to IDLE; Checksum SHALL hold its value until the next accepted Start.
REQ-024 Latency from the Start edge to the first Out_Valid=1 SHALL be 2 edges; each word SHALL take a minimum of 2 cycles.
REQ-025 A full dump with Out_Ready held at 1 SHALL take 2*DEPTH+1 cycles from Start acceptance to the Done pulse.
REQ-026 Start SHALL be ignored while Busy=1.
REQ-027 Abort=1 in FETCH, SEND or FINISH SHALL force IDLE at the next edge with Out_Valid=0 and without a Done pulse; Checksum SHALL keep its partial value.
REQ-028 Abort SHALL take priority over Out_Ready.
REQ-029 In IDLE, Abort SHALL be ignored; if Abort and Start are both high in IDLE, Start SHALL win.
REQ-030 A write to the register file during a dump SHALL be reflected only if it lands before the FETCH edge of that register; no atomic snapshot SHALL be provided.
REQ-031 In IDLE, A SHALL be driven to 0.

Reset
REQ-032 RST=0 SHALL immediately, without waiting for CLK, force IDLE, index=0, A=0, Out_Data=0, Out_Addr=0, Out_Valid=0, Busy=0, Done=0 and Checksum=0.
REQ-033 Reset asserted mid-dump SHALL discard the dump with no Done pulse.
REQ-034 After RST is released, Start SHALL be honoured on the first rising edge.

Verification
REQ-035 Preload reg[i]=i*16'h0101, hold Out_Ready=1, pulse Start -> 32 words with Out_Addr 0..31 in order, Done pulses at cycle 65, and Checksum equals the XOR of all preloaded values.
REQ-036 Hold Out_Ready=0 for 5 cycles while Out_Addr=3 -> Out_Data and Out_Addr stay stable and Out_Valid stays 1; the word is accepted on the first cycle Out_Ready=1.
REQ-037 Raise Abort while Out_Addr=10 is valid -> next edge shows Busy=0 and Out_Valid=0, with no Done pulse; a following Start restarts from address 0.
REQ-038 Pulse Start again at Out_Addr=5 -> Start is ignored and the sequence continues unchanged.
REQ-039 Drop RST asynchronously mid-SEND -> all outputs read 0 before the next CLK edge.
REQ-040 Write reg[20]=32'hDEADBEEF during the fetch of address 7 -> the dumped value for address 20 is 32'hDEADBEEF.

Source files
------------

// File: rtl/reg_dump_reader.sv
// -----------------------------------------------------------------------------
// reg_dump_reader
//
// Walks a register file from index 0 to DEPTH-1 and streams each value out
// over a valid/ready handshake. A running XOR of every captured word is kept
// in Checksum. A dump can be cancelled with Abort. The register file is read
// live, so each value is taken as it stands on the edge that fetches it.
//
// Ports
//   CLK        in   clock, rising edge
//   RST        in   asynchronous reset, active low
//   Start      in   begin a full dump (looked at only while idle)
//   Abort      in   cancel the dump in progress (no Done pulse)
//   A          out  read address into the register file (0 while idle)
//   RD         in   combinational read data for A
//   Out_Data   out  captured register value
//   Out_Addr   out  index of the register held in Out_Data
//   Out_Valid  out  Out_Data/Out_Addr are valid
//   Out_Ready  in   consumer accepts the current word
//   Busy       out  high whenever a dump is running
//   Done       out  one-cycle pulse after the last word is accepted
//   Checksum   out  XOR of all words captured in the current or last dump
//
// DEPTH must be in the range 1..32 because the address ports are 5 bits wide.
// -----------------------------------------------------------------------------
module reg_dump_reader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic             Abort,
  output logic [4:0]       A,
  input  logic [WIDTH-1:0] RD,
  output logic [WIDTH-1:0] Out_Data,
  output logic [4:0]       Out_Addr,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Checksum
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] SEND   = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  localparam logic [4:0] LAST_IDX = 5'(DEPTH - 1);

  logic [1:0]       state_q, state_d;
  logic [4:0]       index_q, index_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [4:0]       addr_q,  addr_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] csum_q,  csum_d;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    csum_d  = csum_q;

    case (state_q)
      IDLE: begin
        // Abort is meaningless here, so Start always wins.
        if (Start) begin
          state_d = FETCH;
          index_d = '0;
          csum_d  = '0;
        end
      end

      FETCH: begin
        if (Abort) begin
          // Nothing captured for this index; checksum keeps its partial value.
          state_d = IDLE;
          valid_d = 1'b0;
        end else begin
          data_d  = RD;
          addr_d  = index_q;
          valid_d = 1'b1;
          csum_d  = csum_q ^ RD;
          state_d = SEND;
        end
      end

      SEND: begin
        // Abort outranks an accepting consumer.
        if (Abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (Out_Ready) begin
          valid_d = 1'b0;
          if (index_q == LAST_IDX) begin
            // Index stops at the last register rather than wrapping.
            state_d = FINISH;
          end else begin
            index_d = index_q + 5'd1;
            state_d = FETCH;
          end
        end
      end

      FINISH: begin
        // Back to idle whether or not Abort is high; Abort only masks Done.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      index_q <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      csum_q  <= csum_d;
    end
  end

  // The address is forced to 0 while idle so a stale index never leaks out.
  assign A         = (state_q == IDLE) ? 5'd0 : index_q;
  assign Out_Data  = data_q;
  assign Out_Addr  = addr_q;
  assign Out_Valid = valid_q;
  assign Busy      = (state_q != IDLE);
  // Done is gated by Abort so an abort in the final cycle suppresses the pulse.
  assign Done      = (state_q == FINISH) && !Abort;
  assign Checksum  = csum_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             Start = 1'b0;
  logic             Abort = 1'b0;
  logic [4:0]       A;
  logic [WIDTH-1:0] RD;
  logic [WIDTH-1:0] Out_Data;
  logic [4:0]       Out_Addr;
  logic             Out_Valid;
  logic             Out_Ready = 1'b1;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Checksum;

  logic [WIDTH-1:0] rf [DEPTH];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  reg_dump_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Start     (Start),
    .Abort     (Abort),
    .A         (A),
    .RD        (RD),
    .Out_Data  (Out_Data),
    .Out_Addr  (Out_Addr),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Busy      (Busy),
    .Done      (Done),
    .Checksum  (Checksum)
  );

  always #5 CLK = ~CLK;

  // Register file read port is combinational.
  assign RD = rf[A];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a dump is a sequence of DEPTH words. Each word first needs
  // one cycle to be read from the register file, then is shown until accepted.
  // After the last acceptance one cycle reports completion.
  // ---------------------------------------------------------------------------
  bit          m_active = 1'b0;   // a dump is running
  bit          m_shown  = 1'b0;   // current word is on the output
  int          m_acc    = 0;      // words accepted so far in this dump
  logic [31:0] m_data   = '0;
  logic [4:0]  m_addr   = '0;
  logic [31:0] m_csum   = '0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_active <= 1'b0;
      m_shown  <= 1'b0;
      m_acc    <= 0;
      m_data   <= '0;
      m_addr   <= '0;
      m_csum   <= '0;
    end else if (!m_active) begin
      if (Start) begin
        m_active <= 1'b1;
        m_acc    <= 0;
        m_shown  <= 1'b0;
        m_csum   <= '0;
      end
    end else if (Abort) begin
      m_active <= 1'b0;
      m_shown  <= 1'b0;
    end else if (m_acc == DEPTH) begin
      m_active <= 1'b0;
    end else if (!m_shown) begin
      m_data  <= rf[m_acc];
      m_addr  <= 5'(m_acc);
      m_shown <= 1'b1;
      m_csum  <= m_csum ^ rf[m_acc];
    end else if (Out_Ready) begin
      m_shown <= 1'b0;
      m_acc   <= m_acc + 1;
    end
  end

  // Compare process: every output against the model on every falling edge.
  always @(negedge CLK) begin
    chk("busy",     32'(Busy),      32'(m_active));
    chk("valid",    32'(Out_Valid), 32'(m_shown));
    chk("out_data", Out_Data,       m_data);
    chk("out_addr", 32'(Out_Addr),  32'(m_addr));
    chk("checksum", Checksum,       m_csum);
    chk("done",     32'(Done),      32'(m_active && (m_acc == DEPTH) && !Abort));
    if (!m_active)
      chk("a_idle", 32'(A), 32'd0);
    else if (!m_shown && m_acc < DEPTH)
      chk("a_fetch", 32'(A), 32'(m_acc));
    if (RST && Out_Valid && Out_Ready && !Abort)
      $display("word addr=%0d data=%h", Out_Addr, Out_Data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int  start_cyc;
  int  done_cyc;
  int  nwords;
  int  exp_a;
  bit  done_seen;

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (Done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk(name, 32'(seen), 32'd1);
    tick();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rf[i] = 32'(i) * 32'h0101;

    // Release reset away from a clock edge.
    repeat (3) @(posedge CLK);
    #3;
    RST = 1'b1;
    tick();
    chk("rst_busy",  32'(Busy),      32'd0);
    chk("rst_valid", 32'(Out_Valid), 32'd0);
    chk("rst_csum",  Checksum,       32'd0);
    chk("rst_a",     32'(A),         32'd0);

    // Full dump, consumer always ready.
    Out_Ready = 1'b1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    start_cyc = cyc;
    nwords = 0;
    exp_a = 0;
    done_seen = 1'b0;
    done_cyc = 0;
    for (int k = 0; k < 200; k++) begin
      if (Out_Valid && Out_Ready) begin
        chk("d1_order", 32'(Out_Addr), 32'(exp_a));
        exp_a++;
        nwords++;
      end
      if (Done) begin
        done_cyc = cyc;
        done_seen = 1'b1;
        break;
      end
      tick();
    end
    chk("d1_done_seen",  32'(done_seen), 32'd1);
    chk("d1_words",      32'(nwords), 32'd32);
    chk("d1_done_cycle", 32'(done_cyc - start_cyc + 1), 32'd65);
    chk("d1_checksum",   Checksum, 32'h0000_0000);
    tick();
    chk("d1_idle", 32'(Busy), 32'd0);

    // Consumer stalls for 5 cycles on address 3.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (A == 5'd3) break;
      tick();
    end
    chk("d2_reach3", 32'(A), 32'd3);
    Out_Ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("d2_hold_valid", 32'(Out_Valid), 32'd1);
      chk("d2_hold_addr",  32'(Out_Addr),  32'd3);
      chk("d2_hold_data",  Out_Data,       32'h0000_0303);
      tick();
    end
    Out_Ready = 1'b1;
    tick();
    chk("d2_accepted", 32'(Out_Valid), 32'd0);
    chk("d2_next_a",   32'(A),         32'd4);
    wait_done("d2_done");

    // Start ignored mid-dump, then abort at address 10, then restart.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (Out_Valid && Out_Addr == 5'd5) break;
      tick();
    end
    chk("d3_reach5", 32'(Out_Addr), 32'd5);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("d3_start_ignored", 32'(A), 32'd6);
    for (int k = 0; k < 50; k++) begin
      if (Out_Valid && Out_Addr == 5'd10) break;
      tick();
    end
    chk("d3_reach10", 32'(Out_Addr), 32'd10);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("d3_abort_busy",  32'(Busy),      32'd0);
    chk("d3_abort_valid", 32'(Out_Valid), 32'd0);
    done_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (Done) done_seen = 1'b1;
      tick();
    end
    chk("d3_no_done", 32'(done_seen), 32'd0);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    chk("d3_restart_valid", 32'(Out_Valid), 32'd1);
    chk("d3_restart_addr",  32'(Out_Addr),  32'd0);
    wait_done("d3_done");

    // Register written during the fetch of address 7 shows up at address 20.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (A == 5'd7 && !Out_Valid) break;
      tick();
    end
    chk("d4_reach7", 32'(A), 32'd7);
    rf[20] = 32'hDEAD_BEEF;
    for (int k = 0; k < 100; k++) begin
      if (Out_Valid && Out_Addr == 5'd20) break;
      tick();
    end
    chk("d4_addr20", 32'(Out_Addr), 32'd20);
    chk("d4_data20", Out_Data, 32'hDEAD_BEEF);
    wait_done("d4_done");

    // Asynchronous reset in the middle of SEND.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (A == 5'd2 && !Out_Valid) break;
      tick();
    end
    Out_Ready = 1'b0;
    tick();
    chk("d5_in_send", 32'(Out_Addr), 32'd2);
    #2;
    RST = 1'b0;
    #1;
    chk("d5_rst_valid", 32'(Out_Valid), 32'd0);
    chk("d5_rst_data",  Out_Data,       32'd0);
    chk("d5_rst_addr",  32'(Out_Addr),  32'd0);
    chk("d5_rst_busy",  32'(Busy),      32'd0);
    chk("d5_rst_done",  32'(Done),      32'd0);
    chk("d5_rst_csum",  Checksum,       32'd0);
    chk("d5_rst_a",     32'(A),         32'd0);
    Start = 1'b1;
    Out_Ready = 1'b1;
    @(negedge CLK);
    #2;
    RST = 1'b1;
    tick();
    Start = 1'b0;
    chk("d5_first_edge_busy", 32'(Busy), 32'd1);
    tick();
    chk("d5_first_word_valid", 32'(Out_Valid), 32'd1);
    chk("d5_first_word_addr",  32'(Out_Addr),  32'd0);
    wait_done("d5_done");

    // Randomised traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      Out_Ready = ($urandom_range(0, 3) != 0);
      Start     = ($urandom_range(0, 5) == 0);
      Abort     = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, DEPTH - 1)] = $urandom;
      tick();
    end
    Start = 1'b0;
    Abort = 1'b0;
    Out_Ready = 1'b1;
    repeat (80) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
